// File: rtl/csr_file.sv
// rtl/csr_file.sv - machine/supervisor CSR file with interrupt request FSM
// Define CSR_FILE_COUNTERS_EN to add mcycle/minstret and the cycle/instret read-only aliases.
module csr_file (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [11:0] i_csr_select,
    input  logic        i_csr_load,
    input  logic [31:0] i_csr_data,
    output logic [31:0] o_csr_reg,
    output logic [31:0] o_mstatus,
    output logic [31:0] o_sstatus,
    output logic [31:0] o_mepc,
    output logic [31:0] o_sepc,
    output logic [31:0] o_mtvec,
    output logic [31:0] o_stvec,
    input  logic        i_exception_ecall,
    input  logic        i_exception_ebreak,
    input  logic        i_interrupt_finnished,
    input  logic        i_instr_retired,
    input  logic        i_mtip,
    input  logic        i_meip,
    input  logic        i_seip,
    output logic        o_mint_req,
    output logic        o_sint_req
);
    localparam logic [31:0] MSTATUS_MASK = 32'h0000_19AA;
    localparam logic [31:0] SSTATUS_MASK = 32'h0000_0122;
    localparam logic [31:0] SIE_MASK     = 32'h0000_0222;
    localparam logic [31:0] MINT_MASK    = 32'h0000_0880;
    localparam logic [31:0] SINT_MASK    = 32'h0000_0202;
    localparam logic [31:0] MSTATUS_RST  = 32'h0000_1800;

    typedef enum logic [1:0] {IDLE, M_PEND, S_PEND} irq_state_t;

    logic [31:0] mstatus, mie, mtvec, mscratch, mepc, mcause;
    logic [31:0] stvec, sscratch, sepc, scause;
    logic        ssip;
    logic [31:0] mip;
    logic [31:0] m_pending, s_pending;
    logic [31:0] irq_word;
    logic [3:0]  cause_code;
    logic        m_finish, s_finish;
    irq_state_t  state;

    assign mip       = {20'b0, i_meip, 1'b0, i_seip, 1'b0, i_mtip, 5'b0, ssip, 1'b0};
    assign m_pending = mip & mie & MINT_MASK;
    assign s_pending = mip & mie & SINT_MASK;
    assign m_finish  = i_interrupt_finnished && (state == M_PEND);
    assign s_finish  = i_interrupt_finnished && (state == S_PEND);
    assign irq_word  = {1'b1, 27'b0, cause_code};

    // MPP=2'b10 is a reserved encoding and collapses to user mode
    function automatic logic [31:0] legal_mstatus(input logic [31:0] d);
        logic [31:0] v;
        v = d & MSTATUS_MASK;
        if (v[12:11] == 2'b10)
            v[12:11] = 2'b00;
        return v;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            cause_code <= 4'd0;
            o_mint_req <= 1'b0;
            o_sint_req <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mstatus[3] && (|m_pending)) begin
                        state      <= M_PEND;
                        o_mint_req <= 1'b1;
                        cause_code <= m_pending[11] ? 4'd11 : 4'd7;
                    end else if (mstatus[1] && (|s_pending)) begin
                        state      <= S_PEND;
                        o_sint_req <= 1'b1;
                        cause_code <= s_pending[9] ? 4'd9 : 4'd1;
                    end
                end
                M_PEND, S_PEND: begin
                    if (i_interrupt_finnished) begin
                        state      <= IDLE;
                        o_mint_req <= 1'b0;
                        o_sint_req <= 1'b0;
                        cause_code <= 4'd0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    o_mint_req <= 1'b0;
                    o_sint_req <= 1'b0;
                end
            endcase
        end
    end

    // Later assignments win: exception over interrupt finish over CSR write
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mstatus  <= MSTATUS_RST;
            mie      <= '0;
            mtvec    <= '0;
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
            stvec    <= '0;
            sscratch <= '0;
            sepc     <= '0;
            scause   <= '0;
            ssip     <= 1'b0;
        end else begin
            if (i_csr_load) begin
                case (i_csr_select)
                    12'h300: mstatus  <= legal_mstatus(i_csr_data);
                    12'h100: mstatus  <= (mstatus & ~SSTATUS_MASK) | (i_csr_data & SSTATUS_MASK);
                    12'h304: mie      <= i_csr_data;
                    12'h104: mie      <= (mie & ~SIE_MASK) | (i_csr_data & SIE_MASK);
                    12'h305: mtvec    <= {i_csr_data[31:2], 2'b00};
                    12'h340: mscratch <= i_csr_data;
                    12'h341: mepc     <= {i_csr_data[31:2], 2'b00};
                    12'h342: mcause   <= i_csr_data;
                    12'h344: ssip     <= i_csr_data[1];
                    12'h105: stvec    <= {i_csr_data[31:2], 2'b00};
                    12'h140: sscratch <= i_csr_data;
                    12'h141: sepc     <= {i_csr_data[31:2], 2'b00};
                    12'h142: scause   <= i_csr_data;
                    default: ;
                endcase
            end
            if (m_finish)
                mcause <= irq_word;
            if (s_finish)
                scause <= irq_word;
            if (i_exception_ecall)
                mcause <= 32'd11;
            else if (i_exception_ebreak)
                mcause <= 32'd3;
        end
    end

`ifdef CSR_FILE_COUNTERS_EN
    logic [63:0] mcycle, minstret;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (i_csr_load && i_csr_select == 12'hB00)
                mcycle[31:0] <= i_csr_data;
            else if (i_csr_load && i_csr_select == 12'hB80)
                mcycle[63:32] <= i_csr_data;
            else
                mcycle <= mcycle + 64'd1;

            if (i_csr_load && i_csr_select == 12'hB02)
                minstret[31:0] <= i_csr_data;
            else if (i_csr_load && i_csr_select == 12'hB82)
                minstret[63:32] <= i_csr_data;
            else if (i_instr_retired)
                minstret <= minstret + 64'd1;
        end
    end
`else
    logic unused_counter_inputs;
    assign unused_counter_inputs = i_instr_retired;
`endif

    always_comb begin
        o_csr_reg = '0;
        case (i_csr_select)
            12'h300: o_csr_reg = mstatus;
            12'h304: o_csr_reg = mie;
            12'h305: o_csr_reg = mtvec;
            12'h340: o_csr_reg = mscratch;
            12'h341: o_csr_reg = mepc;
            12'h342: o_csr_reg = mcause;
            12'h344: o_csr_reg = mip;
            12'h100: o_csr_reg = mstatus & SSTATUS_MASK;
            12'h104: o_csr_reg = mie & SIE_MASK;
            12'h105: o_csr_reg = stvec;
            12'h140: o_csr_reg = sscratch;
            12'h141: o_csr_reg = sepc;
            12'h142: o_csr_reg = scause;
`ifdef CSR_FILE_COUNTERS_EN
            12'hB00, 12'hC00: o_csr_reg = mcycle[31:0];
            12'hB80, 12'hC80: o_csr_reg = mcycle[63:32];
            12'hB02, 12'hC02: o_csr_reg = minstret[31:0];
            12'hB82, 12'hC82: o_csr_reg = minstret[63:32];
`endif
            default: o_csr_reg = '0;
        endcase
    end

    assign o_mstatus = mstatus;
    assign o_sstatus = mstatus & SSTATUS_MASK;
    assign o_mepc    = mepc;
    assign o_sepc    = sepc;
    assign o_mtvec   = mtvec;
    assign o_stvec   = stvec;

endmodule
